// File: rtl/smac_pkg.sv
// Shared types and constants for the ReLU collector datapath.
package smac_pkg;

  localparam int unsigned NLANES = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage : smac_pkg

// File: rtl/relu_nz_popcount.sv
// Counts the lanes of a packed activation word that are non-zero.
module relu_nz_popcount
  import smac_pkg::*;
#(
  parameter int unsigned Pa = 8
) (
  input  logic [NLANES*Pa-1:0] word,
  output logic [CNT_W-1:0]     count_c
);

  // One increment per lane holding any set bit
  always_comb begin
    count_c = '0;
    for (int unsigned k = 0; k < NLANES; k++) begin
      if (word[k*Pa +: Pa] != '0) begin
        count_c = count_c + CNT_W'(1);
      end
    end
  end

endmodule : relu_nz_popcount

// File: rtl/relu_collector.sv
// Serially collects four ReLU lanes (via sel) into one packed word with a
// valid/ready handshake. Optional non-zero lane count: RELU_COLLECTOR_NZ_CNT_EN.
module relu_collector
  import smac_pkg::*;
#(
  parameter int unsigned Pa = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [SEL_W-1:0]     sel,
  input  logic [Pa-1:0]        relu_in,
  output logic [NLANES*Pa-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
`ifdef RELU_COLLECTOR_NZ_CNT_EN
  ,
  output logic [CNT_W-1:0]     nz_count
`endif
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NLANES - 1);

  state_e state;

  // Control FSM with lane capture; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel <= '0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          for (int unsigned k = 0; k < NLANES; k++) begin
            if (sel == SEL_W'(k)) begin
              out_data[k*Pa +: Pa] <= relu_in;
            end
          end
          if (sel == LAST_SEL) begin
            state     <= HOLD;
            sel       <= '0;
            out_valid <= 1'b1;
          end else begin
            sel <= sel + SEL_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sel       <= '0;
            if (start) begin
              state <= SCAN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          sel       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef RELU_COLLECTOR_NZ_CNT_EN
  logic [CNT_W-1:0] nz_next_c;

  // Count is taken over the word as it completes, lane 3 coming straight from relu_in
  relu_nz_popcount #(
    .Pa(Pa)
  ) u_nz_popcount (
    .word    ({relu_in, out_data[(NLANES-1)*Pa-1:0]}),
    .count_c (nz_next_c)
  );

  // Latch the count on the edge that completes the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_count <= '0;
    end else if (state == SCAN && sel == LAST_SEL) begin
      nz_count <= nz_next_c;
    end
  end
`endif

endmodule : relu_collector
